// File: rtl/instruction_issue_queue.sv
// Instruction issue queue: the host pushes words into a circular FIFO. One word at a time is
// held on o_instruction until the core pulses i_done, then the next word (or NOOP) follows.
module instruction_issue_queue #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int DEPTH             = 8,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_push_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] i_push_instruction,
  output logic                         o_push_ready,
  input  logic                         i_flush,
  input  logic                         i_done,
  output logic [INSTRUCTION_WIDTH-1:0] o_instruction,
  output logic                         o_valid,
  output logic [$clog2(DEPTH):0]       o_level,
  output logic [COUNT_WIDTH-1:0]       o_issued_count,
  output logic                         o_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Handshake: a push completes on any cycle where i_push_valid & o_push_ready are both high.
  // A NOOP word or a word offered alongside i_flush completes the handshake but is not stored.
  state_t                       r_state;
  logic [INSTRUCTION_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]             r_wr_ptr;
  logic [PTR_W-1:0]             r_rd_ptr;
  logic [LVL_W-1:0]             r_level;
  logic [INSTRUCTION_WIDTH-1:0] r_instruction;
  logic                         r_valid;
  logic [COUNT_WIDTH-1:0]       r_issued_count;

  logic                         w_push_ready;
  logic                         w_push_store;
  logic                         w_pop;
  logic [LVL_W-1:0]             w_level_next;
  logic [INSTRUCTION_WIDTH-1:0] w_head;

  assign w_push_ready = (r_level != LVL_W'(DEPTH));
  assign w_push_store = i_push_valid & w_push_ready & ~i_flush & (i_push_instruction != '0);
  assign w_pop        = ~i_flush & (r_level != '0) & ((r_state == IDLE) | i_done);
  assign w_head       = r_mem[r_rd_ptr];

  always_comb begin
    w_level_next = r_level;
    if (i_flush) begin
      w_level_next = '0;
    end else begin
      case ({w_push_store, w_pop})
        2'b10:   w_level_next = r_level + LVL_W'(1);
        2'b01:   w_level_next = r_level - LVL_W'(1);
        default: w_level_next = r_level;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and level define which entries are live.
  always_ff @(posedge i_clock) begin
    if (w_push_store) begin
      r_mem[r_wr_ptr] <= i_push_instruction;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_level        <= '0;
      r_instruction  <= '0;
      r_valid        <= 1'b0;
      r_issued_count <= '0;
    end else begin
      if (i_flush) begin
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_push_store) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_level <= w_level_next;

      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_instruction  <= w_head;
            r_valid        <= 1'b1;
            r_issued_count <= r_issued_count + COUNT_WIDTH'(1);
            r_state        <= BUSY;
          end
        end
        BUSY: begin
          // The issued word stays put until the core retires it.
          if (i_done) begin
            if (w_pop) begin
              r_instruction  <= w_head;
              r_issued_count <= r_issued_count + COUNT_WIDTH'(1);
            end else begin
              r_instruction <= '0;
              r_valid       <= 1'b0;
              r_state       <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_push_ready   = w_push_ready;
  assign o_instruction  = r_instruction;
  assign o_valid        = r_valid;
  assign o_level        = r_level;
  assign o_issued_count = r_issued_count;
  assign o_state        = r_state;

endmodule
